// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit adder reused LS nibble first, carry registered.
// Optional subtract path enabled by defining NIBBLE_ADD_SUBTRACT_EN.
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef NIBBLE_ADD_SUBTRACT_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  full_adder_4bit u_fa (
    .a    (a_reg[{idx, 2'b00} +: 4]),
    .b    (b_reg[{idx, 2'b00} +: 4]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // acc with the current nibble merged, so the final ADD cycle can publish it directly
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{idx, 2'b00} +: 4] = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= in_a;
`ifdef NIBBLE_ADD_SUBTRACT_EN
          b_reg <= in_sub ? ~in_b : in_b;
          carry <= in_sub ? 1'b1 : in_cin;
`else
          b_reg <= in_b;
          carry <= in_cin;
`endif
          idx      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= ADD;
        end
        ADD: begin
          acc   <= acc_nxt;
          carry <= nib_cout;
          if (idx == LAST) begin
            out_sum   <= acc_nxt;
            out_cout  <= nib_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
